// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   INSTR_W      instruction / PC width
//   PC_INC       sequential fetch stride in bytes
//   RESET_PC_DEF default first fetch address
//   fq_state_t   fetch queue FSM encoding
//   fq_entry_t   one queued fetch: {pc, instr}
package mips_pkg;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] PC_INC       = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} entries.
//   clock, reset   rising-edge clock, async active-low reset
//   flush          clears pointers/count; wins over same-cycle push and pop
//   push, wdata    write an entry (caller never pushes when full)
//   pop            consume the head (ignored when empty)
//   rdata          head entry, combinational read of registered storage
//   count          entries held
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * INSTR_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~flush;
    assign pop_ok  = pop & (count != '0) & ~flush;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: the head is only observed while count != 0.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, imem req/ack, fetch FIFO,
// valid/ready to decode, redirect flush.
//   clock, reset             rising-edge clock, async active-low reset
//   imem_req/addr/ack/rdata  instruction memory handshake
//   inst_valid/data/pc/ready decode interface (head of queue)
//   redirect, redirect_pc    flush and restart fetch at redirect_pc & ~3
//   q_count                  entries held
module fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    output logic [31:0]              inst_data,
    output logic [31:0]              inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t   state;
    fq_state_t   state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] drain_addr;
    logic        run_en;
    logic        full;
    logic        fetched;
    logic        push;
    logic        pop;
    fq_entry_t   wr_entry;
    fq_entry_t   head;
    logic        unused_pc_lo;

    assign unused_pc_lo = ^redirect_pc[1:0];

    assign full    = (q_count == CW'(DEPTH));
    assign fetched = (state == FQ_RUN) & imem_req & imem_ack;
    assign push    = fetched & ~redirect;
    assign pop     = inst_valid & inst_ready;

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (q_count)
    );

    assign inst_valid = (q_count != '0);
    assign inst_data  = inst_valid ? head.instr : '0;
    assign inst_pc    = inst_valid ? head.pc    : '0;

    // DRAIN re-presents the address that was outstanding when the redirect
    // hit, so the memory sees a stable request until it acks; the word is dropped.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            FQ_RUN: begin
                imem_req = run_en & ~full;
            end
            FQ_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) state_nxt = FQ_RUN;
            end
            default: state_nxt = FQ_RUN;
        endcase
        if (redirect) state_nxt = (imem_req && !imem_ack) ? FQ_DRAIN : FQ_RUN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FQ_RUN;
        else        state <= state_nxt;
    end

    // run_en holds req low for the first cycle after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_en     <= 1'b0;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            run_en <= 1'b1;
            if (redirect) fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (fetched) fetch_pc <= fetch_pc + PC_INC;
            if (redirect && state == FQ_RUN && imem_req && !imem_ack)
                drain_addr <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Memory returns ~addr as the instruction word.
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  q_count;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_count     (q_count)
    );

    always #5 clock = ~clock;
    assign imem_rdata = ~imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic head_is(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, ".pc"},    inst_pc,   pc);
        chk({tag, ".data"},  inst_data, ~pc);
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
        redirect = 1'b0; redirect_pc = '0;

        // Reset values
        @(negedge clock);
        chk("rst.req",   {31'b0, imem_req},   32'd0);
        chk("rst.addr",  imem_addr,           32'h0);
        chk("rst.valid", {31'b0, inst_valid}, 32'd0);
        chk("rst.data",  inst_data,           32'h0);
        chk("rst.pc",    inst_pc,             32'h0);
        chk("rst.cnt",   {29'b0, q_count},    32'd0);

        // 1: streaming, zero-wait memory
        reset = 1'b1;
        @(negedge clock);
        chk("t1.req0",  {31'b0, imem_req},   32'd1);
        chk("t1.addr0", imem_addr,           32'h0);
        chk("t1.val0",  {31'b0, inst_valid}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk("t1.addr", imem_addr, 32'(4 * i));
            head_is("t1", 32'(4 * (i - 1)));
            chk("t1.cnt", {29'b0, q_count}, 32'd1);
        end

        // 2: fill with decode stalled
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; inst_ready = 1'b0;
        @(negedge clock);
        repeat (4) @(negedge clock);
        chk("t2.cnt4", {29'b0, q_count},  32'd4);
        chk("t2.req0", {31'b0, imem_req}, 32'd0);
        head_is("t2.full", 32'h0);
        @(negedge clock);
        chk("t2.hold", {29'b0, q_count}, 32'd4);
        inst_ready = 1'b1;
        @(negedge clock);
        chk("t2.req1", {31'b0, imem_req}, 32'd1);
        chk("t2.addr", imem_addr, 32'h10);
        chk("t2.cnt3", {29'b0, q_count}, 32'd3);
        head_is("t2.pop", 32'h4);

        // 3: redirect with 3 entries and a same-cycle ack
        redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clock);
        redirect = 1'b0;
        chk("t3.cnt",  {29'b0, q_count},    32'd0);
        chk("t3.val",  {31'b0, inst_valid}, 32'd0);
        chk("t3.addr", imem_addr,           32'h400);
        @(negedge clock);
        head_is("t3.head", 32'h400);

        // 4: redirect while a request is outstanding -> drain
        imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clock);
        redirect = 1'b0;
        chk("t4.req",  {31'b0, imem_req}, 32'd1);
        chk("t4.addr", imem_addr,         32'h404);
        chk("t4.cnt",  {29'b0, q_count},  32'd0);
        @(negedge clock);
        chk("t4.addr2", imem_addr, 32'h404);
        @(negedge clock);
        imem_ack = 1'b1;
        @(negedge clock);
        chk("t4.drop", {29'b0, q_count},  32'd0);
        chk("t4.req2", {31'b0, imem_req}, 32'd1);
        chk("t4.addr3", imem_addr,        32'h80);
        @(negedge clock);
        head_is("t4.head", 32'h80);
        chk("t4.cnt1", {29'b0, q_count}, 32'd1);

        // 5: unaligned target, redirect + pop + ack together
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clock);
        redirect = 1'b0;
        chk("t5.cnt",  {29'b0, q_count},    32'd0);
        chk("t5.val",  {31'b0, inst_valid}, 32'd0);
        chk("t5.addr", imem_addr,           32'h100);
        @(negedge clock);
        head_is("t5.head", 32'h100);

        // 6: asynchronous reset with 2 entries
        inst_ready = 1'b0;
        @(negedge clock);
        chk("t6.cnt2", {29'b0, q_count}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t6.req",  {31'b0, imem_req},   32'd0);
        chk("t6.val",  {31'b0, inst_valid}, 32'd0);
        chk("t6.cnt",  {29'b0, q_count},    32'd0);
        chk("t6.addr", imem_addr,           32'h0);
        chk("t6.pc",   inst_pc,             32'h0);
        @(negedge clock);
        reset = 1'b1; inst_ready = 1'b1;
        @(negedge clock);
        chk("t6.req1", {31'b0, imem_req}, 32'd1);
        chk("t6.addr1", imem_addr,        32'h0);
        @(negedge clock);
        head_is("t6.head", 32'h0);

        // fetch_pc wraps past the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clock);
        redirect = 1'b0;
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        chk("wrap.addr1", imem_addr, 32'h0);
        head_is("wrap.head", 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
